// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external combinational 16-bit ALU between two requesters.
// A round-robin grant picks one command in IDLE and latches its operands.
// The latched operands drive the ALU for a single EXEC cycle. The registered
// result and flags are then returned to the winning requester over a
// valid/ready response handshake (RESP).
//
// Optional feature: define ALU_SHARE_OVF_EN to add the rsp_ovf output, a
// registered overflow flag for opcodes 000/001/010.
//
// Parameters
//   DW        operand/result width (must match the ALU, 16)
//   RR_RESET  requester that holds priority after reset (0 or 1)
//
// Ports
//   clk, rst                      rising-edge clock, async active-high reset
//   req_valid[1:0] / req_ready    command handshake, bit i = requester i
//   reqN_a/b/c/opc                operands, carry-in and opcode per requester
//   rsp_valid[1:0] / rsp_ready    response handshake, one-hot to the owner
//   rsp_data, rsp_zer, rsp_neg    registered ALU result and flags
//   rsp_err                       registered illegal-opcode (111) flag
//   rsp_ovf                       registered overflow flag (ALU_SHARE_OVF_EN)
//   alu_inA/inB/inC/opc           operands driven to the shared ALU
//   alu_outW, alu_zer, alu_neg    result and flags from the shared ALU
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int DW       = 16,
  parameter int RR_RESET = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req0_b,
  input  logic [DW-1:0] req1_b,
  input  logic          req0_c,
  input  logic          req1_c,
  input  logic [2:0]    req0_opc,
  input  logic [2:0]    req1_opc,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zer,
  output logic          rsp_neg,
  output logic          rsp_err,
`ifdef ALU_SHARE_OVF_EN
  output logic          rsp_ovf,
`endif
  output logic [DW-1:0] alu_inA,
  output logic [DW-1:0] alu_inB,
  output logic          alu_inC,
  output logic [2:0]    alu_opc,
  input  logic [DW-1:0] alu_outW,
  input  logic          alu_zer,
  input  logic          alu_neg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] OPC_ILL = 3'b111;

  localparam logic PTR_RST = (RR_RESET != 0) ? 1'b1 : 1'b0;

`ifdef ALU_SHARE_OVF_EN
  localparam logic [2:0] OPC_NEG = 3'b000;
  localparam logic [2:0] OPC_INC = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;

  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  // Signed overflow of the operation the ALU just performed, judged from the
  // latched operands and the ALU result.
  function automatic logic ovf_calc(input logic [2:0]    opc,
                                    input logic [DW-1:0] a,
                                    input logic [DW-1:0] b,
                                    input logic [DW-1:0] w);
    logic ovf;
    ovf = 1'b0;
    case (opc)
      OPC_ADD: ovf = (a[DW-1] == b[DW-1]) && (w[DW-1] != a[DW-1]);
      OPC_INC: ovf = (a == MAX_POS);
      OPC_NEG: ovf = (a == MIN_NEG);
      default: ovf = 1'b0;
    endcase
    return ovf;
  endfunction
`endif

  logic [1:0]    state_q,     state_d;
  logic          ptr_q,       ptr_d;
  logic          owner_q,     owner_d;
  logic [DW-1:0] a_q,         a_d;
  logic [DW-1:0] b_q,         b_d;
  logic          c_q,         c_d;
  logic [2:0]    opc_q,       opc_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q,  rsp_data_d;
  logic          rsp_zer_q,   rsp_zer_d;
  logic          rsp_neg_q,   rsp_neg_d;
  logic          rsp_err_q,   rsp_err_d;
`ifdef ALU_SHARE_OVF_EN
  logic          rsp_ovf_q,   rsp_ovf_d;
`endif

  logic          gnt_vld;
  logic          gnt_id;

  // Grant: a lone requester always wins; on contention the pointer decides.
  // req_ready only ever rises for a valid requester, so ready implies a
  // handshake in the same cycle.
  always_comb begin
    gnt_vld = (state_q == S_IDLE) && (req_valid != 2'b00);
    gnt_id  = (req_valid == 2'b11) ? ptr_q : req_valid[1];
  end

  assign req_ready = !gnt_vld ? 2'b00 : (gnt_id ? 2'b10 : 2'b01);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    opc_d       = opc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zer_d   = rsp_zer_q;
    rsp_neg_d   = rsp_neg_q;
    rsp_err_d   = rsp_err_q;
`ifdef ALU_SHARE_OVF_EN
    rsp_ovf_d   = rsp_ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Operand registers feed the ALU directly, so they only change on a
        // handshake and the ALU inputs stay quiet in IDLE and RESP.
        if (gnt_vld) begin
          state_d = S_EXEC;
          owner_d = gnt_id;
          a_d     = gnt_id ? req1_a   : req0_a;
          b_d     = gnt_id ? req1_b   : req0_b;
          c_d     = gnt_id ? req1_c   : req0_c;
          opc_d   = gnt_id ? req1_opc : req0_opc;
        end
      end
      S_EXEC: begin
        state_d     = S_RESP;
        ptr_d       = ~owner_q;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        if (opc_q == OPC_ILL) begin
          // The ALU output is meaningless for 111; return a clean zero.
          rsp_data_d = '0;
          rsp_zer_d  = 1'b1;
          rsp_neg_d  = 1'b0;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = alu_outW;
          rsp_zer_d  = alu_zer;
          rsp_neg_d  = alu_neg;
          rsp_err_d  = 1'b0;
        end
`ifdef ALU_SHARE_OVF_EN
        rsp_ovf_d = ovf_calc(opc_q, a_q, b_q, alu_outW);
`endif
      end
      S_RESP: begin
        // Only the owner's ready bit can retire the response.
        if (rsp_ready[owner_q]) begin
          state_d     = S_IDLE;
          rsp_valid_d = 2'b00;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= PTR_RST;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      opc_q       <= 3'b000;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_zer_q   <= 1'b0;
      rsp_neg_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef ALU_SHARE_OVF_EN
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      opc_q       <= opc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zer_q   <= rsp_zer_d;
      rsp_neg_q   <= rsp_neg_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ALU_SHARE_OVF_EN
      rsp_ovf_q   <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zer   = rsp_zer_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_err   = rsp_err_q;
`ifdef ALU_SHARE_OVF_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif

  assign alu_inA = a_q;
  assign alu_inB = b_q;
  assign alu_inC = c_q;
  assign alu_opc = opc_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [15:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
  logic        req0_c = 1'b0, req1_c = 1'b0;
  logic [2:0]  req0_opc = '0, req1_opc = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [15:0] rsp_data;
  logic        rsp_zer, rsp_neg, rsp_err;
`ifdef ALU_SHARE_OVF_EN
  logic        rsp_ovf;
`endif
  logic [15:0] alu_inA, alu_inB, alu_outW;
  logic        alu_inC, alu_zer, alu_neg;
  logic [2:0]  alu_opc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DW(16), .RR_RESET(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_c(req0_c), .req1_c(req1_c), .req0_opc(req0_opc), .req1_opc(req1_opc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zer(rsp_zer), .rsp_neg(rsp_neg), .rsp_err(rsp_err),
`ifdef ALU_SHARE_OVF_EN
    .rsp_ovf(rsp_ovf),
`endif
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inC(alu_inC), .alu_opc(alu_opc),
    .alu_outW(alu_outW), .alu_zer(alu_zer), .alu_neg(alu_neg)
  );

  // Behavioural shared ALU: 000 negate, 001 increment, 010 add with carry,
  // 011 subtract, 100 and, 101 or, 110 xor, 111 produces junk.
  function automatic logic [15:0] alu_fn(input logic [2:0] opc, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
    case (opc)
      3'b000:  return 16'(17'd0 - {1'b0, a});
      3'b001:  return 16'(a + 16'd1);
      3'b010:  return 16'(a + b + {15'd0, c});
      3'b011:  return 16'(a - b);
      3'b100:  return a & b;
      3'b101:  return a | b;
      3'b110:  return a ^ b;
      default: return 16'(a + b + 16'h1234);
    endcase
  endfunction

  function automatic logic ovf_fn(input logic [2:0] opc, input logic [15:0] a,
                                  input logic [15:0] b, input logic [15:0] w);
    if (opc == 3'b010) return (a[15] == b[15]) && (w[15] != a[15]);
    if (opc == 3'b001) return a == 16'h7FFF;
    if (opc == 3'b000) return a == 16'h8000;
    return 1'b0;
  endfunction

  always_comb begin
    alu_outW = alu_fn(alu_opc, alu_inA, alu_inB, alu_inC);
    alu_zer  = (alu_outW == 16'h0000);
    alu_neg  = alu_outW[15];
  end

  // Stimulus for the next cycle, applied just after a falling edge.
  logic [1:0]  s_valid = 2'b00, s_rsp_ready = 2'b00;
  logic [15:0] s0_a = '0, s1_a = '0, s0_b = '0, s1_b = '0;
  logic        s0_c = 1'b0, s1_c = 1'b0;
  logic [2:0]  s0_opc = '0, s1_opc = '0;

  // Transaction-level reference: one outstanding command, response visible
  // two edges after acceptance, held until the owner accepts it.
  bit          m_pend = 1'b0;
  int          m_age = 0;
  logic        m_owner = 1'b0, m_ptr = 1'b0;
  logic [15:0] m_a = '0, m_b = '0;
  logic        m_c = 1'b0;
  logic [2:0]  m_opc = '0;
  bit          gnt_log[$];

  task automatic model_reset();
    m_pend = 1'b0; m_age = 0; m_ptr = 1'b0; m_owner = 1'b0;
    m_a = '0; m_b = '0; m_c = 1'b0; m_opc = '0;
  endtask

  task automatic rand_ops();
    s0_a = 16'($urandom); s1_a = 16'($urandom);
    s0_b = 16'($urandom); s1_b = 16'($urandom);
    s0_c = 1'($urandom);  s1_c = 1'($urandom);
    s0_opc = 3'($urandom); s1_opc = 3'($urandom);
  endtask

  // One clock cycle: compare registered outputs against the reference,
  // apply stimulus, compare req_ready, then advance the reference.
  task automatic step();
    logic [1:0]  exp_v, exp_rdy;
    logic [15:0] exp_d;
    logic        g;
    @(negedge clk);
    exp_v = (m_pend && m_age == 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    checks++;
    if (rsp_valid !== exp_v) begin
      failures++; $display("FAIL rsp_valid: got %b want %b", rsp_valid, exp_v);
    end
    if (exp_v != 2'b00) begin
      exp_d = (m_opc == 3'b111) ? 16'h0000 : alu_fn(m_opc, m_a, m_b, m_c);
      checks++;
      if (rsp_data !== exp_d || rsp_zer !== (exp_d == 16'h0) ||
          rsp_neg !== exp_d[15] || rsp_err !== (m_opc == 3'b111)) begin
        failures++;
        $display("FAIL rsp_payload: got d=%h z=%b n=%b e=%b want d=%h z=%b n=%b e=%b",
                 rsp_data, rsp_zer, rsp_neg, rsp_err, exp_d, exp_d == 16'h0,
                 exp_d[15], m_opc == 3'b111);
      end
`ifdef ALU_SHARE_OVF_EN
      checks++;
      if (rsp_ovf !== ovf_fn(m_opc, m_a, m_b, alu_fn(m_opc, m_a, m_b, m_c))) begin
        failures++; $display("FAIL rsp_ovf: got %b want %b", rsp_ovf,
                             ovf_fn(m_opc, m_a, m_b, alu_fn(m_opc, m_a, m_b, m_c)));
      end
`endif
    end
    checks++;
    if (alu_inA !== m_a || alu_inB !== m_b || alu_inC !== m_c || alu_opc !== m_opc) begin
      failures++;
      $display("FAIL alu_drive: got a=%h b=%h c=%b o=%b want a=%h b=%h c=%b o=%b",
               alu_inA, alu_inB, alu_inC, alu_opc, m_a, m_b, m_c, m_opc);
    end
    req_valid = s_valid; rsp_ready = s_rsp_ready;
    req0_a = s0_a; req1_a = s1_a; req0_b = s0_b; req1_b = s1_b;
    req0_c = s0_c; req1_c = s1_c; req0_opc = s0_opc; req1_opc = s1_opc;
    #1;
    g = (s_valid == 2'b11) ? m_ptr : s_valid[1];
    exp_rdy = (!m_pend && s_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
    checks++;
    if (req_ready !== exp_rdy) begin
      failures++; $display("FAIL req_ready: got %b want %b", req_ready, exp_rdy);
    end
    if (!m_pend) begin
      if (s_valid != 2'b00) begin
        m_pend = 1'b1; m_age = 1; m_owner = g; m_ptr = ~g;
        m_a = g ? s1_a : s0_a; m_b = g ? s1_b : s0_b;
        m_c = g ? s1_c : s0_c; m_opc = g ? s1_opc : s0_opc;
        gnt_log.push_back(g);
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (s_rsp_ready[m_owner]) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; s_valid = 2'b00;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_data !== 16'h0 ||
        rsp_zer !== 1'b0 || rsp_neg !== 1'b0 || rsp_err !== 1'b0 ||
        alu_inA !== 16'h0 || alu_inB !== 16'h0 || alu_inC !== 1'b0 || alu_opc !== 3'b0) begin
      failures++;
      $display("FAIL reset_values: got rdy=%b v=%b d=%h z=%b n=%b e=%b a=%h b=%h c=%b o=%b want all zero",
               req_ready, rsp_valid, rsp_data, rsp_zer, rsp_neg, rsp_err,
               alu_inA, alu_inB, alu_inC, alu_opc);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    s_valid = 2'b01; s_rsp_ready = 2'b11;
    s0_a = 16'h0005; s0_b = 16'h0003; s0_c = 1'b1; s0_opc = 3'b010;
    step();
    s_valid = 2'b00;
    step();
    step();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 16'h0009 || rsp_zer !== 1'b0 || rsp_neg !== 1'b0) begin
      failures++;
      $display("FAIL single_req: got v=%b d=%h z=%b n=%b want v=01 d=0009 z=0 n=0",
               rsp_valid, rsp_data, rsp_zer, rsp_neg);
    end
    repeat (2) step();
  endtask

  task automatic test_contention();
    do_reset();
    gnt_log.delete();
    s_valid = 2'b11; s_rsp_ready = 2'b11;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      step();
    end
    s_valid = 2'b00;
    step();
    checks++;
    if (gnt_log.size() != 4) begin
      failures++; $display("FAIL contention_count: got %0d grants want 4", gnt_log.size());
    end
    for (int i = 0; i < gnt_log.size(); i++) begin
      checks++;
      if (gnt_log[i] !== i[0]) begin
        failures++; $display("FAIL contention_order[%0d]: got %0d want %0d", i, gnt_log[i], i[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    s_valid = 2'b10; s_rsp_ready = 2'b00;
    s1_a = 16'h0001; s1_b = 16'h5555; s1_c = 1'b0; s1_opc = 3'b000;
    step();
    s_valid = 2'b11;
    step();
    for (int i = 0; i < 5; i++) begin
      s_rsp_ready = i[0] ? 2'b01 : 2'b00;
      rand_ops();
      step();
      checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 16'hFFFF || rsp_neg !== 1'b1 || req_ready !== 2'b00) begin
        failures++;
        $display("FAIL backpressure[%0d]: got v=%b d=%h n=%b rdy=%b want v=10 d=ffff n=1 rdy=00",
                 i, rsp_valid, rsp_data, rsp_neg, req_ready);
      end
    end
    s_valid = 2'b00; s_rsp_ready = 2'b10;
    step();
    step();
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++; $display("FAIL backpressure_done: got v=%b want 00", rsp_valid);
    end
  endtask

  task automatic test_illegal();
    s_valid = 2'b01; s_rsp_ready = 2'b11;
    s0_a = 16'($urandom); s0_b = 16'($urandom); s0_opc = 3'b111;
    step();
    s_valid = 2'b00;
    repeat (2) step();
    checks++;
    if (rsp_data !== 16'h0 || rsp_zer !== 1'b1 || rsp_neg !== 1'b0 || rsp_err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_opc: got d=%h z=%b n=%b e=%b want d=0000 z=1 n=0 e=1",
               rsp_data, rsp_zer, rsp_neg, rsp_err);
    end
    s_valid = 2'b01; s0_opc = 3'b101; s0_a = 16'h00F0; s0_b = 16'h0F00;
    step();
    s_valid = 2'b00;
    repeat (2) step();
    checks++;
    if (rsp_data !== 16'h0FF0 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL illegal_recover: got d=%h e=%b want d=0ff0 e=0", rsp_data, rsp_err);
    end
    step();
  endtask

  task automatic test_reset_resp();
    for (int own = 0; own < 2; own++) begin
      s_valid = own[0] ? 2'b10 : 2'b01; s_rsp_ready = 2'b00;
      rand_ops();
      if (s0_opc == 3'b111) s0_opc = 3'b011;
      step();
      s_valid = 2'b00;
      repeat (2) step();
      rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || rsp_data !== 16'h0 ||
          rsp_err !== 1'b0 || rsp_zer !== 1'b0 || alu_inA !== 16'h0 || alu_opc !== 3'b0) begin
        failures++;
        $display("FAIL reset_in_resp[%0d]: got v=%b rdy=%b d=%h e=%b z=%b a=%h o=%b want all zero",
                 own, rsp_valid, req_ready, rsp_data, rsp_err, rsp_zer, alu_inA, alu_opc);
      end
      #2;
      rst = 1'b0;
      model_reset();
      gnt_log.delete();
      s_valid = 2'b11; s_rsp_ready = 2'b11;
      rand_ops();
      step();
      s_valid = 2'b00;
      repeat (3) step();
      checks++;
      if (gnt_log.size() != 1 || gnt_log[0] !== 1'b0) begin
        failures++; $display("FAIL reset_priority[%0d]: got grants=%0d first=%0d want 1 grant to 0",
                             own, gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : 1'b1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      s_valid = 2'($urandom);
      s_rsp_ready = 2'($urandom);
      rand_ops();
      step();
    end
    s_valid = 2'b00; s_rsp_ready = 2'b11;
    repeat (4) step();
  endtask

`ifdef ALU_SHARE_OVF_EN
  task automatic test_ovf();
    s_valid = 2'b01; s_rsp_ready = 2'b11;
    s0_a = 16'h7FFF; s0_b = 16'h0001; s0_c = 1'b0; s0_opc = 3'b010;
    step();
    s_valid = 2'b00;
    repeat (2) step();
    checks++;
    if (rsp_data !== 16'h8000 || rsp_neg !== 1'b1 || rsp_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_add: got d=%h n=%b o=%b want d=8000 n=1 o=1", rsp_data, rsp_neg, rsp_ovf);
    end
    s_valid = 2'b01; s0_opc = 3'b100;
    step();
    s_valid = 2'b00;
    repeat (2) step();
    checks++;
    if (rsp_ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_and: got o=%b want 0", rsp_ovf);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_illegal();
    test_reset_resp();
`ifdef ALU_SHARE_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
